// File: rtl/icache_pkg.sv
// Shared state type and address-split helpers for the parametrised direct-mapped I-cache.
package icache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } icache_state_e;

    localparam int unsigned MAX_ADDR_W = 64;

    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned off_width(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned lines,
                                              input int unsigned words_per_line);
        return addr_w - 2 - off_width(words_per_line) - idx_width(lines);
    endfunction

    // Beat and offset registers keep at least one bit so single-word lines need no special case.
    function automatic int unsigned beat_width(input int unsigned words_per_line);
        return (words_per_line > 1) ? $clog2(words_per_line) : 1;
    endfunction

    // Extract `width` bits of `addr` starting at `lsb`; a zero width yields zero.
    function automatic logic [MAX_ADDR_W-1:0] addr_field(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int unsigned lsb,
                                                         input int unsigned width);
        logic [MAX_ADDR_W-1:0] mask;
        mask = (width >= MAX_ADDR_W) ? '1 : ((MAX_ADDR_W'(1) << width) - MAX_ADDR_W'(1));
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill controller: miss detection, sequential beat fetch over a valid/ready port, and a sticky
// flag remembering that a flush landed while a line was in flight.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  req_valid,
    input  logic                                  hit,
    input  logic                                  flush,
    input  logic [ADDR_W-1:0]                     line_base,
    input  logic                                  mem_req_ready,
    input  logic                                  mem_resp_valid,
    output icache_state_e                         state,
    output logic [beat_width(WORDS_PER_LINE)-1:0] beat,
    output logic                                  mem_req_valid,
    output logic [ADDR_W-1:0]                     mem_req_addr,
    output logic                                  flush_pending,
    output logic                                  miss_start,
    output logic                                  fill_we,
    output logic                                  fill_last,
    output logic                                  stall
);

    localparam int unsigned BEAT_W = beat_width(WORDS_PER_LINE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    icache_state_e     state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              flush_pending_q, flush_pending_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        flush_pending_d = flush_pending_q;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        miss_start      = 1'b0;
        fill_we         = 1'b0;
        fill_last       = 1'b0;

        unique case (state_q)
            StIdle: begin
                flush_pending_d = 1'b0;
                if (req_valid && !hit) begin
                    miss_start = 1'b1;
                    beat_d     = '0;
                    state_d    = StReq;
                end
            end
            StReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = line_base + (ADDR_W'(beat_q) << 2);
                if (mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    fill_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        fill_last = 1'b1;
                        state_d   = StResp;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = StReq;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A flush while busy must keep the in-flight line from being marked valid.
        if (flush && (state_q != StIdle)) begin
            flush_pending_d = 1'b1;
        end
    end

    assign stall         = (state_q != StIdle) || miss_start;
    assign state         = state_q;
    assign beat          = beat_q;
    assign flush_pending = flush_pending_q;

endmodule

// File: rtl/icache_dm_param.sv
// Parametrised direct-mapped read-only instruction cache with multi-beat refill and flush.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_dm_param
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned LINES          = 4,
    parameter int unsigned WORDS_PER_LINE = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_data,
    output logic              cpu_stall,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);

    localparam int unsigned IDX_W   = idx_width(LINES);
    localparam int unsigned OFF_W   = off_width(WORDS_PER_LINE);
    localparam int unsigned TAG_W   = tag_width(ADDR_W, LINES, WORDS_PER_LINE);
    localparam int unsigned BEAT_W  = beat_width(WORDS_PER_LINE);
    localparam int unsigned WIDX_W  = IDX_W + OFF_W;
    localparam int unsigned IDX_LSB = 2 + OFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam int unsigned NWORDS  = LINES * WORDS_PER_LINE;

    // Data is stored flat; a word's slot is {index, offset}.
    function automatic logic [WIDX_W-1:0] widx(input logic [IDX_W-1:0]  idx,
                                               input logic [BEAT_W-1:0] off);
        return (WIDX_W'(idx) << OFF_W) | WIDX_W'(off);
    endfunction

    logic [DATA_W-1:0] data_q [NWORDS];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q, valid_d;

    logic [ADDR_W-1:0] req_addr_q;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic [IDX_W-1:0]  cpu_idx, req_idx;
    logic [BEAT_W-1:0] cpu_off, req_off;
    logic [TAG_W-1:0]  cpu_tag, req_tag;
    logic [ADDR_W-1:0] line_base;
    logic              hit, hit_resp;

    icache_state_e     state;
    logic [BEAT_W-1:0] beat;
    logic              flush_pending, miss_start, fill_we, fill_last;

    always_comb begin
        cpu_off   = BEAT_W'(addr_field(MAX_ADDR_W'(cpu_req_addr), 2, OFF_W));
        cpu_idx   = IDX_W'(addr_field(MAX_ADDR_W'(cpu_req_addr), IDX_LSB, IDX_W));
        cpu_tag   = TAG_W'(addr_field(MAX_ADDR_W'(cpu_req_addr), TAG_LSB, TAG_W));
        req_off   = BEAT_W'(addr_field(MAX_ADDR_W'(req_addr_q), 2, OFF_W));
        req_idx   = IDX_W'(addr_field(MAX_ADDR_W'(req_addr_q), IDX_LSB, IDX_W));
        req_tag   = TAG_W'(addr_field(MAX_ADDR_W'(req_addr_q), TAG_LSB, TAG_W));
        line_base = req_addr_q & ~((ADDR_W'(1) << IDX_LSB) - ADDR_W'(1));
    end

    // A same-cycle flush turns any lookup into a miss.
    assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag) && !flush;
    assign hit_resp = (state == StIdle) && cpu_req_valid && hit;

    icache_refill_fsm #(
        .ADDR_W         (ADDR_W),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_refill_fsm (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (cpu_req_valid),
        .hit            (hit),
        .flush          (flush),
        .line_base      (line_base),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .state          (state),
        .beat           (beat),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .flush_pending  (flush_pending),
        .miss_start     (miss_start),
        .fill_we        (fill_we),
        .fill_last      (fill_last),
        .stall          (cpu_stall)
    );

    always_comb begin
        valid_d = valid_q;
        if (fill_last && !flush_pending) begin
            valid_d[req_idx] = 1'b1;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // The missed word was either written on an earlier beat or is arriving on the last one.
    always_comb begin
        resp_valid_d = hit_resp || fill_last;
        resp_data_d  = resp_data_q;
        if (hit_resp) begin
            resp_data_d = data_q[widx(cpu_idx, cpu_off)];
        end else if (fill_last) begin
            resp_data_d = (req_off == beat) ? mem_resp_data : data_q[widx(req_idx, req_off)];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q      <= '0;
            req_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            if (miss_start) begin
                req_addr_q <= cpu_req_addr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && fill_we) begin
            data_q[widx(req_idx, beat)] <= mem_resp_data;
        end
        if (reset_n && fill_last) begin
            tag_q[req_idx] <= req_tag;
        end
    end

    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_data  = resp_data_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hits_q, perf_misses_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else begin
            if (hit_resp && (perf_hits_q != '1)) begin
                perf_hits_q <= perf_hits_q + 32'd1;
            end
            if (miss_start && (perf_misses_q != '1)) begin
                perf_misses_q <= perf_misses_q + 32'd1;
            end
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule
